// File: rtl/lock_controller_pkg.sv
// Shared definitions for the digital lock controller: FSM state encodings,
// keypad digit range, default 12 MHz timing constants and a key-validity helper.
package lock_controller_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_BLINK    = 3'd3,
    ST_UNLOCKED = 3'd4,
    ST_PROGRAM  = 3'd5,
    ST_LOCKOUT  = 3'd6
  } state_e;

  localparam logic [3:0] KEY_MIN = 4'd1;
  localparam logic [3:0] KEY_MAX = 4'd9;

  localparam int TIMER_W = 32;

  // Default timing at 12 MHz: 5 s entry idle, 10 s unlocked, 30 s lockout.
  localparam int unsigned DEF_ENTRY_TIMEOUT  = 60_000_000;
  localparam int unsigned DEF_UNLOCK_CYCLES  = 120_000_000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 360_000_000;

  // Only keypad digits 1..9 count as presses; 0 and 10..15 are noise/unused keys.
  function automatic logic key_valid(input logic [3:0] key);
    return (key >= KEY_MIN) && (key <= KEY_MAX);
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad, blinker handshake and status bundle of the lock controller.
// master = the controller, slave = keypad/blinker/LED side.
interface lock_controller_if;
  logic [3:0] button;
  logic       bstate;
  logic       blink_done;
  logic       blink_start;
  logic       blink_type;
  logic       unlocked;
  logic       lockout;
  logic       prog_mode;
  logic [2:0] digit_count;
  logic [1:0] fail_count;

  modport master (
    input  button, bstate, blink_done,
    output blink_start, blink_type, unlocked, lockout, prog_mode,
           digit_count, fail_count
  );

  modport slave (
    output button, bstate, blink_done,
    input  blink_start, blink_type, unlocked, lockout, prog_mode,
           digit_count, fail_count
  );
endinterface

// File: rtl/lock_controller_key_event.sv
// Key release detector: commits a digit when the key-held level falls.
// press is a registered one-cycle pulse; digit is the key code sampled with it.
module key_event
  import lock_controller_pkg::*;
(
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic [3:0] button,
  input  logic       bstate,
  output logic       press,
  output logic [3:0] digit
);

  logic       bstate_d_q, bstate_d_d;
  logic       press_q, press_d;
  logic [3:0] digit_q, digit_d;

  // Release edge qualified by a valid digit code.
  always_comb begin
    bstate_d_d = bstate;
    press_d    = bstate_d_q & ~bstate & key_valid(button);
    digit_d    = button;
  end

  // Delay register plus registered press/digit outputs.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      bstate_d_q <= 1'b0;
      press_q    <= 1'b0;
      digit_q    <= 4'd0;
    end else begin
      bstate_d_q <= bstate_d_d;
      press_q    <= press_d;
      digit_q    <= digit_d;
    end
  end

  assign press = press_q;
  assign digit = digit_q;

endmodule

// File: rtl/lock_controller.sv
// Digital lock sequencing FSM: collects digits, checks them against the stored
// code, drives the blinker handshake and tracks unlock/lockout/program status.
// A single shared down-counter provides entry, unlock and lockout timeouts.
module lock_controller
  import lock_controller_pkg::*;
#(
  parameter int unsigned             CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]   CODE_INIT      = 16'h1234,
  parameter int unsigned             PROG_KEY       = 9,
  parameter int unsigned             MAX_FAILS      = 3,
  parameter int unsigned             ENTRY_TIMEOUT  = DEF_ENTRY_TIMEOUT,
  parameter int unsigned             UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int unsigned             LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                hwclk,
  input  logic                rst_n,
  lock_controller_if.master   bus
);

  localparam int BUF_W = 4 * CODE_LEN;

  logic             press;
  logic [3:0]       digit;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] entry_buf_q, entry_buf_d;
  logic [BUF_W-1:0] code_q, code_d;
  logic [2:0]       digit_count_q, digit_count_d;
  logic [1:0]       fail_count_q, fail_count_d;
  logic             blink_start_q, blink_start_d;
  logic             blink_type_q, blink_type_d;
  logic             from_prog_q, from_prog_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic [BUF_W-1:0] buf_shift;
  logic [2:0]       digit_count_inc;
  logic             last_digit;
  logic             timer_reload;

  key_event u_key_event (
    .hwclk  (hwclk),
    .rst_n  (rst_n),
    .button (bus.button),
    .bstate (bus.bstate),
    .press  (press),
    .digit  (digit)
  );

  // Entry buffer shifts in from the LSB; a one-digit code is just the digit.
  generate
    if (CODE_LEN == 1) begin : g_shift_single
      assign buf_shift = digit;
    end else begin : g_shift_multi
      assign buf_shift = {entry_buf_q[BUF_W-5:0], digit};
    end
  endgenerate

  assign digit_count_inc = digit_count_q + 3'd1;
  assign last_digit      = (digit_count_inc == 3'(CODE_LEN));

  // Reload value for the shared timer, chosen by the state being entered.
  function automatic logic [TIMER_W-1:0] timer_load(input state_e st);
    case (st)
      ST_ENTRY, ST_PROGRAM: return TIMER_W'(ENTRY_TIMEOUT);
      ST_UNLOCKED:          return TIMER_W'(UNLOCK_CYCLES);
      ST_LOCKOUT:           return TIMER_W'(LOCKOUT_CYCLES);
      default:              return '0;
    endcase
  endfunction

  // Next-state, datapath and timer logic; presses take priority over expiry.
  always_comb begin
    state_d        = state_q;
    entry_buf_d    = entry_buf_q;
    code_d         = code_q;
    digit_count_d  = digit_count_q;
    fail_count_d   = fail_count_q;
    blink_start_d  = blink_start_q;
    blink_type_d   = blink_type_q;
    from_prog_d    = from_prog_q;
    timer_reload   = 1'b0;
    timer_d        = (timer_q != '0) ? timer_q - TIMER_W'(1) : '0;

    case (state_q)
      ST_LOCKED: begin
        if (press) begin
          entry_buf_d   = buf_shift;
          digit_count_d = 3'd1;
          state_d       = last_digit ? ST_CHECK : ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (press) begin
          entry_buf_d   = buf_shift;
          digit_count_d = digit_count_inc;
          timer_reload  = 1'b1;
          if (last_digit) state_d = ST_CHECK;
        end else if (timer_q == '0) begin
          entry_buf_d   = '0;
          digit_count_d = 3'd0;
          state_d       = ST_LOCKED;
        end
      end

      ST_CHECK: begin
        if (entry_buf_q == code_q) begin
          fail_count_d = 2'd0;
          blink_type_d = 1'b1;
        end else begin
          fail_count_d = (fail_count_q == 2'd3) ? 2'd3 : fail_count_q + 2'd1;
          blink_type_d = 1'b0;
        end
        digit_count_d = 3'd0;
        blink_start_d = 1'b1;
        from_prog_d   = 1'b0;
        state_d       = ST_BLINK;
      end

      ST_BLINK: begin
        if (blink_start_q && bus.blink_done) begin
          blink_start_d = 1'b0;
          if (blink_type_q)
            state_d = from_prog_q ? ST_LOCKED : ST_UNLOCKED;
          else if ({30'd0, fail_count_q} >= MAX_FAILS)
            state_d = ST_LOCKOUT;
          else
            state_d = ST_LOCKED;
        end
      end

      ST_UNLOCKED: begin
        if (press) begin
          if (digit == 4'(PROG_KEY)) begin
            digit_count_d = 3'd0;
            state_d       = ST_PROGRAM;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (timer_q == '0) begin
          state_d = ST_LOCKED;
        end
      end

      ST_PROGRAM: begin
        if (press) begin
          entry_buf_d   = buf_shift;
          digit_count_d = digit_count_inc;
          timer_reload  = 1'b1;
          if (last_digit) begin
            code_d        = buf_shift;
            digit_count_d = 3'd0;
            blink_type_d  = 1'b1;
            blink_start_d = 1'b1;
            from_prog_d   = 1'b1;
            state_d       = ST_BLINK;
          end
        end else if (timer_q == '0) begin
          entry_buf_d   = '0;
          digit_count_d = 3'd0;
          state_d       = ST_LOCKED;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_count_d = 2'd0;
          state_d      = ST_LOCKED;
        end
      end

      default: state_d = ST_LOCKED;
    endcase

    if ((state_d != state_q) || timer_reload)
      timer_d = timer_load(state_d);
  end

  // State, code and counter registers; reset restores the factory code.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q       <= ST_LOCKED;
      entry_buf_q   <= '0;
      code_q        <= CODE_INIT;
      digit_count_q <= 3'd0;
      fail_count_q  <= 2'd0;
      blink_start_q <= 1'b0;
      blink_type_q  <= 1'b0;
      from_prog_q   <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      entry_buf_q   <= entry_buf_d;
      code_q        <= code_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      blink_start_q <= blink_start_d;
      blink_type_q  <= blink_type_d;
      from_prog_q   <= from_prog_d;
      timer_q       <= timer_d;
    end
  end

  assign bus.blink_start = blink_start_q;
  assign bus.blink_type  = blink_type_q;
  assign bus.unlocked    = (state_q == ST_UNLOCKED) || (state_q == ST_PROGRAM);
  assign bus.lockout     = (state_q == ST_LOCKOUT);
  assign bus.prog_mode   = (state_q == ST_PROGRAM);
  assign bus.digit_count = digit_count_q;
  assign bus.fail_count  = fail_count_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed testbench for lock_controller with shortened timeouts.
module tb_lock_controller;

  logic hwclk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 hwclk = ~hwclk;

  lock_controller_if lc_bus();

  lock_controller #(
    .CODE_LEN       (4),
    .CODE_INIT      (16'h1234),
    .PROG_KEY       (9),
    .MAX_FAILS      (3),
    .ENTRY_TIMEOUT  (50),
    .UNLOCK_CYCLES  (300),
    .LOCKOUT_CYCLES (100)
  ) dut (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .bus   (lc_bus)
  );

  // Press and release a key; returns on the negedge after the state update.
  task automatic press_key(input logic [3:0] k);
    @(negedge hwclk);
    lc_bus.button = k;
    lc_bus.bstate = 1'b1;
    @(negedge hwclk);
    @(negedge hwclk);
    lc_bus.bstate = 1'b0;
    @(negedge hwclk);
    @(negedge hwclk);
    lc_bus.button = 4'd0;
    $display("press key=%0d digit_count=%0d unlocked=%0d fail_count=%0d",
             k, lc_bus.digit_count, lc_bus.unlocked, lc_bus.fail_count);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press_key(a);
    press_key(b);
    press_key(c);
    press_key(d);
  endtask

  // Wait for a blink request, check it, then acknowledge it.
  task automatic finish_blink(input logic exp_type, input logic [1:0] exp_fail,
                              input string name);
    int n = 0;
    while (lc_bus.blink_start !== 1'b1 && n < 10) begin
      @(negedge hwclk);
      n++;
    end
    checks++;
    if (lc_bus.blink_start !== 1'b1)
      $display("FAIL %s_blink_start got=%b exp=1", name, lc_bus.blink_start);
    if (lc_bus.blink_start !== 1'b1) failures++;
    checks++;
    if (lc_bus.blink_type !== exp_type) begin
      $display("FAIL %s_blink_type got=%b exp=%b", name, lc_bus.blink_type, exp_type);
      failures++;
    end
    checks++;
    if (lc_bus.fail_count !== exp_fail) begin
      $display("FAIL %s_fail_count got=%0d exp=%0d", name, lc_bus.fail_count, exp_fail);
      failures++;
    end
    lc_bus.blink_done = 1'b1;
    @(negedge hwclk);
    lc_bus.blink_done = 1'b0;
    checks++;
    if (lc_bus.blink_start !== 1'b0) begin
      $display("FAIL %s_blink_drop got=%b exp=0", name, lc_bus.blink_start);
      failures++;
    end
    $display("blink type=%0d fail_count=%0d done", exp_type, lc_bus.fail_count);
  endtask

  task automatic test_reset();
    lc_bus.button = 4'd0;
    lc_bus.bstate = 1'b0;
    lc_bus.blink_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge hwclk);
    checks++;
    if ({lc_bus.blink_start, lc_bus.blink_type, lc_bus.unlocked, lc_bus.lockout,
         lc_bus.prog_mode, lc_bus.digit_count, lc_bus.fail_count} !== 10'd0) begin
      $display("FAIL reset_outputs got=%b exp=0",
               {lc_bus.blink_start, lc_bus.blink_type, lc_bus.unlocked, lc_bus.lockout,
                lc_bus.prog_mode, lc_bus.digit_count, lc_bus.fail_count});
      failures++;
    end
    rst_n = 1'b1;
    @(negedge hwclk);
  endtask

  task automatic test_correct_code();
    // First press with exact latency: digit_count moves 2 cycles after release.
    @(negedge hwclk);
    lc_bus.button = 4'd1;
    lc_bus.bstate = 1'b1;
    @(negedge hwclk);
    @(negedge hwclk);
    lc_bus.bstate = 1'b0;
    @(posedge hwclk); #1;
    checks++;
    if (lc_bus.digit_count !== 3'd0) begin
      $display("FAIL latency_early got=%0d exp=0", lc_bus.digit_count);
      failures++;
    end
    @(posedge hwclk); #1;
    checks++;
    if (lc_bus.digit_count !== 3'd1) begin
      $display("FAIL latency_dc1 got=%0d exp=1", lc_bus.digit_count);
      failures++;
    end
    @(negedge hwclk);
    lc_bus.button = 4'd0;
    press_key(4'd2);
    checks++;
    if (lc_bus.digit_count !== 3'd2) begin
      $display("FAIL correct_dc2 got=%0d exp=2", lc_bus.digit_count);
      failures++;
    end
    press_key(4'd3);
    checks++;
    if (lc_bus.digit_count !== 3'd3) begin
      $display("FAIL correct_dc3 got=%0d exp=3", lc_bus.digit_count);
      failures++;
    end
    press_key(4'd4);
    checks++;
    if (lc_bus.digit_count !== 3'd4) begin
      $display("FAIL correct_dc4 got=%0d exp=4", lc_bus.digit_count);
      failures++;
    end
    @(negedge hwclk);
    checks++;
    if (lc_bus.blink_start !== 1'b1 || lc_bus.digit_count !== 3'd0) begin
      $display("FAIL correct_check_cycle got start=%b dc=%0d exp start=1 dc=0",
               lc_bus.blink_start, lc_bus.digit_count);
      failures++;
    end
    finish_blink(1'b1, 2'd0, "correct");
    checks++;
    if (lc_bus.unlocked !== 1'b1 || lc_bus.fail_count !== 2'd0) begin
      $display("FAIL correct_unlocked got=%b fail=%0d exp=1 fail=0",
               lc_bus.unlocked, lc_bus.fail_count);
      failures++;
    end
  endtask

  task automatic test_unlock_timeout();
    int n = 0;
    while (lc_bus.unlocked === 1'b1 && n < 400) begin
      @(negedge hwclk);
      n++;
    end
    checks++;
    if (lc_bus.unlocked !== 1'b0 || n < 250) begin
      $display("FAIL unlock_timeout got unlocked=%b cycles=%0d exp unlocked=0 cycles~300",
               lc_bus.unlocked, n);
      failures++;
    end
  endtask

  task automatic test_relock();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    finish_blink(1'b1, 2'd0, "relock_unlock");
    @(negedge hwclk);
    lc_bus.button = 4'd5;
    lc_bus.bstate = 1'b1;
    @(negedge hwclk);
    @(negedge hwclk);
    lc_bus.bstate = 1'b0;
    @(posedge hwclk); #1;
    checks++;
    if (lc_bus.unlocked !== 1'b1) begin
      $display("FAIL relock_early got=%b exp=1", lc_bus.unlocked);
      failures++;
    end
    @(posedge hwclk); #1;
    checks++;
    if (lc_bus.unlocked !== 1'b0) begin
      $display("FAIL relock_cleared got=%b exp=0", lc_bus.unlocked);
      failures++;
    end
    @(negedge hwclk);
    lc_bus.button = 4'd0;
    $display("relock key=5 unlocked=%0d", lc_bus.unlocked);
  endtask

  task automatic test_invalid_keys();
    press_key(4'd1);
    press_key(4'd0);
    checks++;
    if (lc_bus.digit_count !== 3'd1) begin
      $display("FAIL invalid_key0 got=%0d exp=1", lc_bus.digit_count);
      failures++;
    end
    press_key(4'd12);
    checks++;
    if (lc_bus.digit_count !== 3'd1) begin
      $display("FAIL invalid_key12 got=%0d exp=1", lc_bus.digit_count);
      failures++;
    end
    press_key(4'd2);
    press_key(4'd3);
    press_key(4'd4);
    finish_blink(1'b1, 2'd0, "invalid");
    checks++;
    if (lc_bus.unlocked !== 1'b1) begin
      $display("FAIL invalid_unlocked got=%b exp=1", lc_bus.unlocked);
      failures++;
    end
    press_key(4'd7);
    checks++;
    if (lc_bus.unlocked !== 1'b0) begin
      $display("FAIL invalid_relock got=%b exp=0", lc_bus.unlocked);
      failures++;
    end
  endtask

  task automatic test_lockout();
    int n = 0;
    for (int i = 1; i <= 3; i++) begin
      enter4(4'd1, 4'd1, 4'd1, 4'd1);
      finish_blink(1'b0, 2'(i), "wrong");
      checks++;
      if (lc_bus.lockout !== (i == 3)) begin
        $display("FAIL lockout_after_%0d got=%b exp=%b", i, lc_bus.lockout, (i == 3));
        failures++;
      end
    end
    press_key(4'd1);
    checks++;
    if (lc_bus.digit_count !== 3'd0 || lc_bus.lockout !== 1'b1) begin
      $display("FAIL lockout_ignore got dc=%0d lockout=%b exp dc=0 lockout=1",
               lc_bus.digit_count, lc_bus.lockout);
      failures++;
    end
    while (lc_bus.lockout === 1'b1 && n < 300) begin
      @(negedge hwclk);
      n++;
    end
    checks++;
    if (lc_bus.lockout !== 1'b0 || lc_bus.fail_count !== 2'd0) begin
      $display("FAIL lockout_expire got lockout=%b fail=%0d exp lockout=0 fail=0",
               lc_bus.lockout, lc_bus.fail_count);
      failures++;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    enter4(4'd2, 4'd2, 4'd2, 4'd2);
    finish_blink(1'b0, 2'd1, "timeout_setup");
    press_key(4'd1);
    press_key(4'd2);
    checks++;
    if (lc_bus.digit_count !== 3'd2) begin
      $display("FAIL timeout_partial got=%0d exp=2", lc_bus.digit_count);
      failures++;
    end
    repeat (30) @(negedge hwclk);
    checks++;
    if (lc_bus.digit_count !== 3'd2) begin
      $display("FAIL timeout_early got=%0d exp=2", lc_bus.digit_count);
      failures++;
    end
    while (lc_bus.digit_count !== 3'd0 && n < 100) begin
      @(negedge hwclk);
      n++;
    end
    checks++;
    if (lc_bus.digit_count !== 3'd0 || lc_bus.fail_count !== 2'd1 || lc_bus.unlocked !== 1'b0) begin
      $display("FAIL timeout_abort got dc=%0d fail=%0d unl=%b exp dc=0 fail=1 unl=0",
               lc_bus.digit_count, lc_bus.fail_count, lc_bus.unlocked);
      failures++;
    end
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    finish_blink(1'b1, 2'd0, "after_timeout");
    press_key(4'd3);
  endtask

  task automatic test_reprogram();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    finish_blink(1'b1, 2'd0, "prog_unlock");
    press_key(4'd9);
    checks++;
    if (lc_bus.prog_mode !== 1'b1 || lc_bus.unlocked !== 1'b1 || lc_bus.digit_count !== 3'd0) begin
      $display("FAIL prog_enter got prog=%b unl=%b dc=%0d exp 1 1 0",
               lc_bus.prog_mode, lc_bus.unlocked, lc_bus.digit_count);
      failures++;
    end
    press_key(4'd5);
    press_key(4'd6);
    press_key(4'd7);
    checks++;
    if (lc_bus.prog_mode !== 1'b1 || lc_bus.digit_count !== 3'd3) begin
      $display("FAIL prog_entry got prog=%b dc=%0d exp prog=1 dc=3",
               lc_bus.prog_mode, lc_bus.digit_count);
      failures++;
    end
    press_key(4'd8);
    finish_blink(1'b1, 2'd0, "prog_store");
    checks++;
    if (lc_bus.unlocked !== 1'b0 || lc_bus.prog_mode !== 1'b0) begin
      $display("FAIL prog_return got unl=%b prog=%b exp 0 0",
               lc_bus.unlocked, lc_bus.prog_mode);
      failures++;
    end
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    finish_blink(1'b0, 2'd1, "old_code");
    checks++;
    if (lc_bus.unlocked !== 1'b0) begin
      $display("FAIL old_code_denied got=%b exp=0", lc_bus.unlocked);
      failures++;
    end
    enter4(4'd5, 4'd6, 4'd7, 4'd8);
    finish_blink(1'b1, 2'd0, "new_code");
    checks++;
    if (lc_bus.unlocked !== 1'b1) begin
      $display("FAIL new_code_granted got=%b exp=1", lc_bus.unlocked);
      failures++;
    end
    press_key(4'd3);
  endtask

  task automatic test_reset_mid_blink();
    int n = 0;
    enter4(4'd5, 4'd6, 4'd7, 4'd8);
    while (lc_bus.blink_start !== 1'b1 && n < 10) begin
      @(negedge hwclk);
      n++;
    end
    checks++;
    if (lc_bus.blink_start !== 1'b1) begin
      $display("FAIL midblink_start got=%b exp=1", lc_bus.blink_start);
      failures++;
    end
    rst_n = 1'b0;
    @(negedge hwclk);
    checks++;
    if ({lc_bus.blink_start, lc_bus.blink_type, lc_bus.unlocked, lc_bus.lockout,
         lc_bus.prog_mode, lc_bus.digit_count, lc_bus.fail_count} !== 10'd0) begin
      $display("FAIL midblink_reset got=%b exp=0",
               {lc_bus.blink_start, lc_bus.blink_type, lc_bus.unlocked, lc_bus.lockout,
                lc_bus.prog_mode, lc_bus.digit_count, lc_bus.fail_count});
      failures++;
    end
    rst_n = 1'b1;
    @(negedge hwclk);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    finish_blink(1'b1, 2'd0, "code_restored");
    checks++;
    if (lc_bus.unlocked !== 1'b1) begin
      $display("FAIL code_restored_unlocked got=%b exp=1", lc_bus.unlocked);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_unlock_timeout();
    test_relock();
    test_invalid_keys();
    test_lockout();
    test_timeout();
    test_reprogram();
    test_reset_mid_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
